// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, default width, opcodes.
package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int INSTR_W_DEF = 9;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_LD  = 3'b101;
    localparam logic [2:0] OP_ST  = 3'b110;
    localparam logic [2:0] OP_LDI = 3'b111;

endpackage

// File: rtl/instr_sequencer_buf.sv
// Program buffer: one write port, one registered read port with write-through on address match.
module instr_sequencer_buf
    import instr_sequencer_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [INSTR_W-1:0]         wr_data,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [INSTR_W-1:0]         rd_data
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A word written in the same cycle a run starts may be the one read out.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers a program from the host and issues it in order to the datapath.
// Define INSTR_SEQUENCER_STEP_EN to add a step input that gates each issue during a run.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    input  logic [INSTR_W-1:0]         wr_instr,
    output logic                       wr_ready,
    input  logic                       clr,
    input  logic                       start,
    input  logic                       abort,
`ifdef INSTR_SEQUENCER_STEP_EN
    input  logic                       step,
`endif
    output logic                       issue_valid,
    output logic [INSTR_W-1:0]         issue_instr,
    output logic [$clog2(DEPTH)-1:0]   pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

`ifdef INSTR_SEQUENCER_STEP_EN
    localparam bit STEP_MODE = 1'b1;
    logic go;
    assign go = step;
`else
    localparam bit STEP_MODE = 1'b0;
    logic go;
    assign go = 1'b1;
`endif

    state_t        state;
    logic [AW:0]   ptr;
    logic          accept;
    logic          clr_eff;
    logic          wr_en;
    logic [AW:0]   count_next;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    always_comb begin
        accept     = wr_valid && wr_ready;
        clr_eff    = clr && (state == IDLE);
        wr_en      = accept && !clr_eff;
        count_next = clr_eff ? '0 : count + {{AW{1'b0}}, accept};
        rd_en      = 1'b0;
        rd_addr    = ptr[AW-1:0];
        case (state)
            IDLE: begin
                if (start && (count_next != '0) && !STEP_MODE) begin
                    rd_en   = 1'b1;
                    rd_addr = '0;
                end
            end
            RUN: begin
                if (!abort && (ptr != count) && go) begin
                    rd_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    instr_sequencer_buf #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (count[AW-1:0]),
        .wr_data (wr_instr),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (issue_instr)
    );

    // ptr is the next index to issue; pc reports the index being issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            pc          <= '0;
            count       <= '0;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_ready    <= 1'b1;
        end else begin
            count       <= count_next;
            issue_valid <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    wr_ready <= (count_next < FULL);
                    if (start) begin
                        wr_ready <= 1'b0;
                        pc       <= '0;
                        if (count_next != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            if (STEP_MODE) begin
                                ptr <= '0;
                            end else begin
                                ptr         <= (AW+1)'(1);
                                issue_valid <= 1'b1;
                            end
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        pc       <= '0;
                        ptr      <= '0;
                        wr_ready <= (count < FULL);
                    end else if (ptr == count) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pc    <= '0;
                        ptr   <= '0;
                    end else if (go) begin
                        issue_valid <= 1'b1;
                        pc          <= ptr[AW-1:0];
                        ptr         <= ptr + (AW+1)'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    pc       <= '0;
                    ptr      <= '0;
                    wr_ready <= (count < FULL);
                end
            endcase
        end
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter INSTR_W, default 9, SHALL set the instruction width (3-bit opcode, 6-bit operand field).
REQ-002 Parameter DEPTH, default 16, SHALL set the number of program buffer entries; it is a power of two, at least 2.
REQ-003 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  host offers a program word.
- wr_instr  in  INSTR_W  program word.
- wr_ready  out  1  buffer accepts a word this cycle.
- clr  in  1  empty the program buffer.
- start  in  1  begin a run.
- abort  in  1  terminate a run.
- issue_valid  out  1  issue_instr is valid for the CPU datapath this cycle.
- issue_instr  out  INSTR_W  instruction presented to the CPU datapath.
- pc  out  log2(DEPTH)  index of the current or next issued word.
- count  out  log2(DEPTH)+1  number of loaded words.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when a run completes.

Function
REQ-004 The FSM SHALL have states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-005 In IDLE, wr_ready SHALL be 1 iff count < DEPTH; a word SHALL be accepted when wr_valid and wr_ready are both 1, stored at index count, and count SHALL increment.
REQ-006 In RUN and DONE, wr_ready SHALL be 0 and clr SHALL be ignored.
REQ-007 clr in IDLE SHALL set count to 0 next cycle; if clr and an accepted write coincide, clr SHALL win and the word SHALL be dropped.
REQ-008 start in IDLE with count > 0 SHALL enter RUN; issue_valid SHALL be 1 with issue_instr = entry 0 in the first cycle after start is sampled.
REQ-009 A write accepted in the same cycle as start SHALL be included in the run.
REQ-010 In RUN, one word SHALL be issued per cycle in order 0..count-1, with pc equal to the issued index; after index count-1 the FSM SHALL enter DONE.
REQ-011 start in IDLE with count = 0 SHALL enter DONE directly, with no issue.
REQ-012 DONE SHALL last one cycle with done = 1, then return to IDLE with pc = 0; buffer contents and count SHALL be retained for a re-run.
REQ-013 start in RUN or DONE SHALL be ignored.
REQ-014 abort in RUN SHALL return to IDLE next cycle with issue_valid = 0, pc = 0 and no done pulse; abort SHALL take priority over completion in the same cycle.
REQ-015 busy SHALL be 1 exactly in RUN; issue_valid SHALL be 0 outside RUN, and issue_instr SHALL then hold its last value.

Reset
REQ-016 rst SHALL force IDLE with pc = 0, count = 0, issue_valid = 0, issue_instr = 0, busy = 0 and done = 0; buffer contents need not be cleared.
REQ-017 rst during RUN SHALL abandon the run with no done pulse.

Configuration
REQ-018 With macro INSTR_SEQUENCER_STEP_EN defined, an extra input step (1 bit) SHALL exist; in RUN, a word SHALL be issued only in a cycle following a sampled step = 1, otherwise issue_valid = 0 and pc holds.
REQ-019 Without INSTR_SEQUENCER_STEP_EN, the step port SHALL be absent and RUN SHALL issue every cycle.

Structure
REQ-020 A shared package SHALL hold the state enum (IDLE, RUN, DONE), the INSTR_W default and the opcode constants (ADD=000 through LDI=111).
REQ-021 The program buffer SHALL be a separate sub-module, instr_sequencer_buf (1 write port, 1 synchronous read port).

Verification
REQ-022 Load 3 words (ADD, AND, OR: 000_00_01_10, 001_00_01_10, 010_00_01_10), start -> issue_valid high 3 consecutive cycles, pc 0,1,2, done pulse on the 4th cycle, count stays 3.
REQ-023 Write 16 words -> wr_ready = 0 at count = 16; a 17th wr_valid is not accepted and count stays 16.
REQ-024 start with count = 0 -> done pulses the next cycle, issue_valid never rises.
REQ-025 Load 5 words, start, assert abort in the 2nd issue cycle -> issue_valid = 0 next cycle, pc = 0, no done; a re-start issues all 5 words from index 0.
REQ-026 Write and start in the same cycle with count = 2 -> 3 words issued; clr with wr_valid in IDLE -> count = 0.
REQ-027 With INSTR_SEQUENCER_STEP_EN defined, 2 words loaded, step pulsed every 3rd cycle -> exactly one issue per step pulse, done after the 2nd issue.
